// File: rtl/mux_pipe.sv
// mux_pipe: registered multi-lane operand selector between the input buffer
// and the PE row.
//
// Each of NUMBER_LANES lanes picks one of NUMBER_INPUT_MUX signed words per
// beat. A select code that is out of range yields a zero word and raises the
// lane's zero flag, so the PE array can skip pruned operands.
//
// In sequencer mode each lane's select comes from a rotation counter
// instead of sel_mux_i. Lane l then uses (c + l) mod N.
//
// Ports:
//   clk_i       clock, rising edge
//   rst_i       asynchronous reset, active high
//   data_in_i   [0:N-1] candidate words, W = I_WIDTH + F_WIDTH bits, signed
//   sel_mux_i   [0:L-1] per-lane select codes, used when seq_mode_i = 0
//   seq_mode_i  1 = lane selects come from the rotation counter
//   seq_clr_i   synchronous clear of the rotation counter
//   valid_i     input beat valid
//   ready_o     block can accept a beat
//   data_out_o  [0:L-1] selected words, registered
//   zero_o      per-lane flag: word was forced to zero by an out-of-range select
//   valid_o     output beat valid
//   ready_i     downstream accepts the output beat
module mux_pipe #(
   parameter int I_WIDTH          = 8,
   parameter int F_WIDTH          = 8,
   parameter int NUMBER_INPUT_MUX = 8,
   parameter int SEL_WIDTH_MUX    = 4,
   parameter int NUMBER_LANES     = 4
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic signed [I_WIDTH+F_WIDTH-1:0]   data_in_i [0:NUMBER_INPUT_MUX-1],
   input  logic        [SEL_WIDTH_MUX-1:0]     sel_mux_i [0:NUMBER_LANES-1],
   input  logic                                seq_mode_i,
   input  logic                                seq_clr_i,
   input  logic                                valid_i,
   output logic                                ready_o,
   output logic signed [I_WIDTH+F_WIDTH-1:0]   data_out_o [0:NUMBER_LANES-1],
   output logic        [NUMBER_LANES-1:0]      zero_o,
   output logic                                valid_o,
   input  logic                                ready_i
);

   localparam int W = I_WIDTH + F_WIDTH;

   logic [SEL_WIDTH_MUX-1:0] cnt;
   logic [SEL_WIDTH_MUX-1:0] cnt_base;
   logic [SEL_WIDTH_MUX-1:0] cnt_next;
   logic [SEL_WIDTH_MUX-1:0] lane_sel  [0:NUMBER_LANES-1];
   logic signed [W-1:0]      lane_word [0:NUMBER_LANES-1];
   logic [NUMBER_LANES-1:0]  lane_zero;

   logic signed [W-1:0]      skid_data [0:NUMBER_LANES-1];
   logic [NUMBER_LANES-1:0]  skid_zero;
   logic                     skid_valid;

   logic accept;
   logic load_out;

   // ready_o depends only on the skid flag, so there is no combinational
   // path from ready_i back to the input side.
   assign ready_o  = ~skid_valid;
   assign accept   = valid_i & ready_o;
   assign load_out = ~valid_o | ready_i;

   // A clear in the same cycle makes the current beat rotate from zero.
   assign cnt_base = seq_clr_i ? '0 : cnt;

   always_comb begin
      for (int l = 0; l < NUMBER_LANES; l++) begin
         lane_sel[l] = sel_mux_i[l];
         if (seq_mode_i) begin
            lane_sel[l] = SEL_WIDTH_MUX'((int'(cnt_base) + l) % NUMBER_INPUT_MUX);
         end
      end
   end

   // The select is compared against each legal index. A code that matches
   // none of them falls through to the zero word with the flag set.
   always_comb begin
      for (int l = 0; l < NUMBER_LANES; l++) begin
         lane_word[l] = '0;
         lane_zero[l] = 1'b1;
         for (int k = 0; k < NUMBER_INPUT_MUX; k++) begin
            if (lane_sel[l] == SEL_WIDTH_MUX'(k)) begin
               lane_word[l] = data_in_i[k];
               lane_zero[l] = 1'b0;
            end
         end
      end
   end

   always_comb begin
      cnt_next = cnt;
      if (seq_clr_i) begin
         cnt_next = (accept & seq_mode_i) ? SEL_WIDTH_MUX'(1 % NUMBER_INPUT_MUX) : '0;
      end else if (accept & seq_mode_i) begin
         cnt_next = (cnt == SEL_WIDTH_MUX'(NUMBER_INPUT_MUX - 1)) ? '0 : cnt + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt        <= '0;
         valid_o    <= 1'b0;
         zero_o     <= '0;
         skid_valid <= 1'b0;
         skid_zero  <= '0;
         for (int l = 0; l < NUMBER_LANES; l++) begin
            data_out_o[l] <= '0;
            skid_data[l]  <= '0;
         end
      end else begin
         cnt <= cnt_next;
         if (load_out) begin
            // While the skid is full, ready_o is low and no accept can
            // compete with the skid entry for the output register.
            if (skid_valid) begin
               data_out_o <= skid_data;
               zero_o     <= skid_zero;
               valid_o    <= 1'b1;
               skid_valid <= 1'b0;
            end else if (accept) begin
               data_out_o <= lane_word;
               zero_o     <= lane_zero;
               valid_o    <= 1'b1;
            end else begin
               valid_o    <= 1'b0;
            end
         end else if (accept) begin
            skid_data  <= lane_word;
            skid_zero  <= lane_zero;
            skid_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mux_pipe.sv
// Self-checking bench for mux_pipe. It uses table vectors, directed
// sequencer and backpressure runs, a random handshake run and a mid-stream
// reset, all checked against an in-order scoreboard queue.
module tb_mux_pipe;

   localparam int IW = 8;
   localparam int FW = 8;
   localparam int W  = IW + FW;
   localparam int N  = 8;
   localparam int SW = 4;
   localparam int L  = 4;

   logic clk = 1'b0;
   logic rst;
   logic signed [W-1:0]  din  [0:N-1];
   logic        [SW-1:0] sel  [0:L-1];
   logic                 seq_mode;
   logic                 seq_clr;
   logic                 valid_i;
   logic                 ready_o;
   logic signed [W-1:0]  dout [0:L-1];
   logic        [L-1:0]  zero_o;
   logic                 valid_o;
   logic                 ready_i;

   always #5 clk = ~clk;

   mux_pipe #(
      .I_WIDTH(IW), .F_WIDTH(FW), .NUMBER_INPUT_MUX(N),
      .SEL_WIDTH_MUX(SW), .NUMBER_LANES(L)
   ) dut (
      .clk_i(clk), .rst_i(rst), .data_in_i(din), .sel_mux_i(sel),
      .seq_mode_i(seq_mode), .seq_clr_i(seq_clr), .valid_i(valid_i),
      .ready_o(ready_o), .data_out_o(dout), .zero_o(zero_o),
      .valid_o(valid_o), .ready_i(ready_i)
   );

   typedef struct packed {
      logic [L-1:0][W-1:0] data;
      logic [L-1:0]        zero;
   } exp_t;

   typedef struct packed {
      logic [L-1:0][SW-1:0] sel;
      logic [W-1:0]         din1;
      exp_t                 e;
   } vec_t;

   exp_t q[$];
   int   checks    = 0;
   int   errors    = 0;
   int   cnt_m     = 0;
   int   acc_total = 0;

   int c_a [0:9] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
   int c_b [0:9] = '{2, 3, 4, 5, 6, 0, 1, 2, 3, 4};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic exp_t model(input bit mode, input bit clr, input int c);
      exp_t e;
      int   s;
      for (int l = 0; l < L; l++) begin
         s = mode ? (((clr ? 0 : c) + l) % N) : int'(sel[l]);
         if (s < N) begin
            e.data[l] = din[s];
            e.zero[l] = 1'b0;
         end else begin
            e.data[l] = '0;
            e.zero[l] = 1'b1;
         end
      end
      return e;
   endfunction

   function automatic exp_t seq_exp(input int c);
      exp_t e;
      for (int l = 0; l < L; l++) begin
         e.data[l] = din[(c + l) % N];
         e.zero[l] = 1'b0;
      end
      return e;
   endfunction

   function automatic vec_t mk(input logic [SW-1:0] s0, input logic [SW-1:0] s1,
                               input logic [SW-1:0] s2, input logic [SW-1:0] s3,
                               input logic [W-1:0] d1,
                               input logic [W-1:0] e0, input logic [W-1:0] e1,
                               input logic [W-1:0] e2, input logic [W-1:0] e3,
                               input logic [L-1:0] z);
      vec_t v;
      v.sel[0] = s0; v.sel[1] = s1; v.sel[2] = s2; v.sel[3] = s3;
      v.din1 = d1;
      v.e.data[0] = e0; v.e.data[1] = e1; v.e.data[2] = e2; v.e.data[3] = e3;
      v.e.zero = z;
      return v;
   endfunction

   task automatic check_reset_outputs(input string tag);
      logic [L-1:0][W-1:0] ad;
      for (int l = 0; l < L; l++) ad[l] = dout[l];
      check({tag, "_valid_o"}, 64'(valid_o), 64'd0);
      check({tag, "_ready_o"}, 64'(ready_o), 64'd1);
      check({tag, "_data_out_o"}, 64'(ad), 64'd0);
      check({tag, "_zero_o"}, 64'(zero_o), 64'd0);
   endtask

   // One clock: check the outputs on the falling edge against the queue
   // head, then account for the transfer and accept at the rising edge.
   task automatic cycle(input bit use_e, input exp_t e_in);
      bit                  acc;
      bit                  xfer;
      exp_t                e;
      exp_t                h;
      logic [L-1:0][W-1:0] ad;
      @(negedge clk);
      check("valid_o", 64'(valid_o), 64'(q.size() != 0));
      check("ready_o", 64'(ready_o), 64'(q.size() < 2));
      if (q.size() != 0 && valid_o) begin
         h = q[0];
         for (int l = 0; l < L; l++) ad[l] = dout[l];
         check("data_out_o", 64'(ad), 64'(h.data));
         check("zero_o", 64'(zero_o), 64'(h.zero));
      end
      xfer = (q.size() != 0) && ready_i;
      acc  = valid_i && (q.size() < 2);
      e    = use_e ? e_in : model(seq_mode, seq_clr, cnt_m);
      @(posedge clk);
      #1;
      if (xfer) void'(q.pop_front());
      if (acc) begin
         q.push_back(e);
         acc_total++;
      end
      if (seq_clr) cnt_m = (acc && seq_mode) ? (1 % N) : 0;
      else if (acc && seq_mode) cnt_m = (cnt_m == N - 1) ? 0 : cnt_m + 1;
   endtask

   initial begin
      vec_t tbl [0:3];
      int   target;

      rst = 1'b1; valid_i = 1'b0; ready_i = 1'b1; seq_mode = 1'b0; seq_clr = 1'b0;
      for (int i = 0; i < N; i++) din[i] = W'((i + 1) << 8);
      for (int l = 0; l < L; l++) sel[l] = '0;

      tbl[0] = mk(7, 0, 3, 3, 16'h0200, 16'h0800, 16'h0100, 16'h0400, 16'h0400, 4'b0000);
      tbl[1] = mk(8, 15, 2, 9, 16'h0200, 16'h0000, 16'h0000, 16'h0300, 16'h0000, 4'b1011);
      tbl[2] = mk(1, 1, 0, 8, 16'hFF80, 16'hFF80, 16'hFF80, 16'h0100, 16'h0000, 4'b1000);
      tbl[3] = mk(6, 5, 4, 0, 16'h0200, 16'h0700, 16'h0600, 16'h0500, 16'h0100, 4'b0000);

      #2;
      check_reset_outputs("reset");
      @(posedge clk);
      #1 rst = 1'b0;

      // table vectors, mode 0, no backpressure
      for (int i = 0; i < 4; i++) begin
         for (int l = 0; l < L; l++) sel[l] = tbl[i].sel[l];
         din[1]  = tbl[i].din1;
         valid_i = 1'b1;
         cycle(1'b1, tbl[i].e);
      end
      valid_i = 1'b0;
      din[1]  = 16'h0200;
      repeat (2) cycle(1'b0, '0);

      // sequencer mode, hand-derived rotation base per beat
      seq_mode = 1'b1;
      valid_i  = 1'b1;
      for (int i = 0; i < 10; i++) cycle(1'b1, seq_exp(c_a[i]));
      for (int i = 0; i < 10; i++) begin
         seq_clr = (i == 5);
         cycle(1'b1, seq_exp(c_b[i]));
      end
      seq_clr  = 1'b0;
      seq_mode = 1'b0;
      valid_i  = 1'b0;
      repeat (2) cycle(1'b0, '0);

      // backpressure: two beats fill the output and the skid, the third is refused
      ready_i = 1'b0;
      valid_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         for (int l = 0; l < L; l++) sel[l] = SW'((i * 3 + l) % 10);
         cycle(1'b0, '0);
      end
      check("bp_ready_low", 64'(ready_o), 64'd0);
      ready_i = 1'b1;
      valid_i = 1'b0;
      repeat (3) cycle(1'b0, '0);
      check("bp_ready_back", 64'(ready_o), 64'd1);

      // random handshake run
      target = acc_total + 1000;
      for (int cyc = 0; cyc < 20000 && acc_total < target; cyc++) begin
         valid_i  = 1'($urandom_range(0, 1));
         ready_i  = 1'($urandom_range(0, 1));
         seq_mode = ($urandom_range(0, 3) == 0);
         seq_clr  = ($urandom_range(0, 7) == 0);
         for (int i = 0; i < N; i++) din[i] = W'($urandom_range(0, 65535));
         for (int l = 0; l < L; l++) sel[l] = SW'($urandom_range(0, 15));
         cycle(1'b0, '0);
      end
      check("random_beats", 64'(acc_total >= target), 64'd1);
      valid_i = 1'b0; ready_i = 1'b1; seq_mode = 1'b0; seq_clr = 1'b0;
      repeat (3) cycle(1'b0, '0);

      // fill output and skid with the counter advanced, then reset mid-stream
      ready_i  = 1'b0;
      valid_i  = 1'b1;
      seq_mode = 1'b1;
      seq_clr  = 1'b1;
      cycle(1'b0, '0);
      seq_clr  = 1'b0;
      cycle(1'b0, '0);
      check("pre_reset_full", 64'(ready_o), 64'd0);
      rst = 1'b1;
      #1;
      check_reset_outputs("async_reset");
      q.delete();
      cnt_m = 0;
      @(negedge clk);
      rst     = 1'b0;
      valid_i = 1'b0;
      ready_i = 1'b1;
      repeat (2) cycle(1'b0, '0);
      valid_i = 1'b1;
      cycle(1'b1, seq_exp(0));
      valid_i  = 1'b0;
      seq_mode = 1'b0;
      repeat (2) cycle(1'b0, '0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mux_pipe.md
Name: mux_pipe

Overview:
- Parametrised, registered multi-lane successor to the single combinational activation selector.
- NUMBER_LANES independent lanes each pick one of NUMBER_INPUT_MUX signed fixed-point words per beat.
- Out-of-range select codes produce a zero word plus a zero flag, so the PE array can skip pruned operands.
- Sits between the input buffer and the PE row; valid/ready on both sides with a 2-entry skid buffer, plus a rotating-select sequencer mode for dense operation.

Parameters:
- I_WIDTH, 8, integer bits of each data word.
- F_WIDTH, 8, fractional bits; word width W = I_WIDTH + F_WIDTH.
- NUMBER_INPUT_MUX, 8, number of candidate input words (N >= 1).
- SEL_WIDTH_MUX, 4, select code width; must satisfy 2^SEL_WIDTH_MUX > NUMBER_INPUT_MUX.
- NUMBER_LANES, 4, number of independent output lanes (L >= 1).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- data_in_i  in  W x N (signed unpacked array [0:N-1])  candidate words.
- sel_mux_i  in  SEL_WIDTH_MUX x L (array [0:L-1])  per-lane select, used when seq_mode_i=0.
- seq_mode_i  in  1  1 = lane selects come from the internal rotation counter.
- seq_clr_i  in  1  synchronous clear of the rotation counter.
- valid_i  in  1  input beat valid.
- ready_o  out  1  block can accept a beat.
- data_out_o  out  W x L (signed array [0:L-1])  selected words, registered.
- zero_o  out  L  per-lane flag: selected word forced to zero by an out-of-range select.
- valid_o  out  1  output beat valid.
- ready_i  in  1  downstream accepts the output beat.

Behaviour:
- Reset (asynchronous, rst_i high):
  - valid_o=0, data_out_o all 0, zero_o=0, skid empty, rotation counter cnt=0.
  - ready_o=1 while in reset and immediately after.
- Handshake:
  - Input accept = valid_i & ready_o.
  - Output transfer = valid_o & ready_i.
  - ready_o = ~skid_valid (registered flag; no combinational path from ready_i).
- Lane select:
  - seq_mode_i=0: s_l = sel_mux_i[l].
  - seq_mode_i=1: s_l = (c + l) mod N, where c = seq_clr_i ? 0 : cnt.
- Lane result:
  - s_l < N: word = data_in_i[s_l], zero bit = 0.
  - s_l >= N: word = 0, zero bit = 1.
  - Both are evaluated at the accepting edge; no arithmetic and no width change.
- Counter:
  - cnt_next = seq_clr_i ? (accept & seq_mode_i ? 1 mod N : 0) : (accept & seq_mode_i ? (cnt == N-1 ? 0 : cnt+1) : cnt).
  - Clear has priority; with N=1, cnt stays 0.
  - In mode 0 the counter holds its value.
- Pipeline:
  - The output register loads when (!valid_o | ready_i), taking the skid entry if skid_valid, else the accepted beat.
  - If an accept occurs while valid_o & !ready_i, the beat goes to the skid register (skid_valid=1, ready_o drops next cycle).
  - When the output transfers and skid_valid=1, skid moves to the output and skid_valid=0.
  - Latency is 1 cycle from accept to valid_o when unstalled; sustained throughput is 1 beat/cycle.
  - With no new data to load, valid_o clears after a transfer.
- Stability: data_out_o, zero_o and valid_o are held constant while valid_o & !ready_i.
- Ordering: beats emerge in acceptance order, with no loss or duplication under any ready_i pattern.
- Select/data inputs are ignored when valid_i=0. When ready_o=0, valid_i may be asserted but nothing is captured.
- Mode change: seq_mode_i may change between beats and takes effect on the next accepted beat.
- Reset mid-stream discards output and skid contents; no beat is emitted after reset deassertion until a new accept.

Test Plan:
- Reset, then data_in_i={0x0100,0x0200,...,0x0800}, sel={7,0,3,3}, valid_i=1, ready_i=1 -> next cycle valid_o=1, data_out_o={0x0800,0x0100,0x0400,0x0400}, zero_o=0000.
- Select codes {8,15,2,9} -> data_out_o={0,0,0x0300,0}, zero_o (lane3..0)=1011; negative input 0xFF80 on sel 1 passes through unchanged and signed.
- seq_mode_i=1, 10 consecutive beats -> lane0 selects 0,1,...,7,0,1 and lane3 selects 3,4,5,6,7,0,...; seq_clr_i on beat 5 -> that beat uses c=0 and the next beat uses c=1.
- Backpressure: ready_i=0 for 3 cycles while valid_i=1 -> one beat in output, one in skid, ready_o=0 after 2 accepts, outputs stable. ready_i=1 -> both beats drain in order, ready_o returns to 1, no loss.
- Random valid_i/ready_i (50%) for 1000 beats against a scoreboard model -> exact in-order match, stall stability holds, zero_o consistent.
- Assert rst_i asynchronously with output and skid full -> valid_o=0 and ready_o=1 immediately, cnt=0, and data_out_o=0 before the next clock edge.
